// File: rtl/hazard_scoreboard.sv
// Issue-control scoreboard between Decode and Execute. Keeps a pending-write
// counter per architectural register and blocks issue on RAW hazards, WAW
// counter saturation, or when the in-flight writer limit is reached.
module hazard_scoreboard #(
    parameter int unsigned N_REGS       = 32,
    parameter int unsigned CNT_W        = 2,
    parameter int unsigned MAX_INFLIGHT = 3,
    parameter bit          WB_BYPASS    = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_issue_valid,
    input  logic [4:0]        i_rs1,
    input  logic [4:0]        i_rs2,
    input  logic              i_rs1_used,
    input  logic              i_rs2_used,
    input  logic [4:0]        i_rd,
    input  logic              i_rd_wr,
    input  logic              i_ex_stall,
    input  logic              i_wb_wr,
    input  logic [4:0]        i_wb_rd,
    input  logic              i_flush,
    output logic              o_issue,
    output logic              o_stall,
    output logic [N_REGS-1:0] o_busy_mask,
    output logic [1:0]        o_inflight,
    output logic              o_underflow
);

    localparam logic [CNT_W-1:0] CntMax = '1;
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
    localparam logic [1:0]       IfMax  = 2'(MAX_INFLIGHT);

    logic [CNT_W-1:0] r_cnt [N_REGS];
    logic [CNT_W-1:0] w_cnt_nxt [N_REGS];
    logic [1:0]       r_inflight;
    logic [1:0]       w_inflight_nxt;
    logic             r_underflow;

    logic w_wb_hit;
    logic w_rs1_haz;
    logic w_rs2_haz;
    logic w_waw_full;
    logic w_lim_full;
    logic w_rd_writer;
    logic w_inc;
    logic w_underflow_set;
    logic [N_REGS-1:0] w_inc_vec;
    logic [N_REGS-1:0] w_dec_vec;

    // Hazard detection and issue qualification from registered state plus inputs
    always_comb begin
        w_wb_hit    = i_wb_wr && (i_wb_rd != 5'd0) && (r_cnt[i_wb_rd] != '0);
        w_rd_writer = i_rd_wr && (i_rd != 5'd0);
        // A source whose single pending write retires this cycle can be bypassed
        w_rs1_haz   = i_rs1_used && (i_rs1 != 5'd0) && (r_cnt[i_rs1] != '0) &&
                      !(WB_BYPASS && w_wb_hit && (i_wb_rd == i_rs1) &&
                        (r_cnt[i_rs1] == CntOne));
        w_rs2_haz   = i_rs2_used && (i_rs2 != 5'd0) && (r_cnt[i_rs2] != '0) &&
                      !(WB_BYPASS && w_wb_hit && (i_wb_rd == i_rs2) &&
                        (r_cnt[i_rs2] == CntOne));
        w_waw_full  = w_rd_writer && (r_cnt[i_rd] == CntMax) &&
                      !(w_wb_hit && (i_wb_rd == i_rd));
        w_lim_full  = w_rd_writer && (r_inflight == IfMax) && !w_wb_hit;
        o_issue     = i_issue_valid && !i_ex_stall && !i_flush && !w_rs1_haz &&
                      !w_rs2_haz && !w_waw_full && !w_lim_full;
        o_stall     = i_issue_valid && !o_issue && !i_flush;
        w_inc       = o_issue && w_rd_writer;
        w_underflow_set = i_wb_wr && (i_wb_rd != 5'd0) && (r_cnt[i_wb_rd] == '0) &&
                          !i_flush;
    end

    // Next-state for per-register counters and in-flight count
    always_comb begin
        w_inc_vec = N_REGS'(w_inc) << i_rd;
        w_dec_vec = N_REGS'(w_wb_hit) << i_wb_rd;
        for (int r = 0; r < N_REGS; r++) begin
            w_cnt_nxt[r] = r_cnt[r];
            if (i_flush) begin
                w_cnt_nxt[r] = '0;
            end else if (w_inc_vec[r] && !w_dec_vec[r]) begin
                w_cnt_nxt[r] = r_cnt[r] + CntOne;
            end else if (w_dec_vec[r] && !w_inc_vec[r]) begin
                w_cnt_nxt[r] = r_cnt[r] - CntOne;
            end
        end
        w_inflight_nxt = r_inflight;
        if (i_flush) begin
            w_inflight_nxt = 2'd0;
        end else if (w_inc && !w_wb_hit) begin
            w_inflight_nxt = r_inflight + 2'd1;
        end else if (w_wb_hit && !w_inc) begin
            w_inflight_nxt = r_inflight - 2'd1;
        end
    end

    // State registers; underflow flag is sticky until reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < N_REGS; r++) begin
                r_cnt[r] <= '0;
            end
            r_inflight  <= 2'd0;
            r_underflow <= 1'b0;
        end else begin
            for (int r = 0; r < N_REGS; r++) begin
                r_cnt[r] <= w_cnt_nxt[r];
            end
            r_inflight <= w_inflight_nxt;
            if (w_underflow_set) begin
                r_underflow <= 1'b1;
            end
        end
    end

    // Status outputs are pure functions of registered state
    always_comb begin
        for (int r = 0; r < N_REGS; r++) begin
            o_busy_mask[r] = (r_cnt[r] != '0);
        end
        o_busy_mask[0] = 1'b0;
        o_inflight     = r_inflight;
        o_underflow    = r_underflow;
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed self-checking bench for hazard_scoreboard.
module tb_hazard_scoreboard;

    logic        clk;
    logic        rst_n;
    logic        i_issue_valid;
    logic [4:0]  i_rs1;
    logic [4:0]  i_rs2;
    logic        i_rs1_used;
    logic        i_rs2_used;
    logic [4:0]  i_rd;
    logic        i_rd_wr;
    logic        i_ex_stall;
    logic        i_wb_wr;
    logic [4:0]  i_wb_rd;
    logic        i_flush;
    logic        o_issue;
    logic        o_stall;
    logic [31:0] o_busy_mask;
    logic [1:0]  o_inflight;
    logic        o_underflow;

    int tests = 0;
    int fails = 0;

    hazard_scoreboard #(
        .N_REGS(32),
        .CNT_W(2),
        .MAX_INFLIGHT(3),
        .WB_BYPASS(1'b1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .i_issue_valid(i_issue_valid),
        .i_rs1(i_rs1),
        .i_rs2(i_rs2),
        .i_rs1_used(i_rs1_used),
        .i_rs2_used(i_rs2_used),
        .i_rd(i_rd),
        .i_rd_wr(i_rd_wr),
        .i_ex_stall(i_ex_stall),
        .i_wb_wr(i_wb_wr),
        .i_wb_rd(i_wb_rd),
        .i_flush(i_flush),
        .o_issue(o_issue),
        .o_stall(o_stall),
        .o_busy_mask(o_busy_mask),
        .o_inflight(o_inflight),
        .o_underflow(o_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge, then let combinational logic settle
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rd, input logic wr, input logic wbw,
                         input logic [4:0] wbrd, input logic fl);
        i_issue_valid = v;
        i_rs1 = rs1;
        i_rs1_used = u1;
        i_rs2 = 5'd0;
        i_rs2_used = 1'b0;
        i_rd = rd;
        i_rd_wr = wr;
        i_ex_stall = 1'b0;
        i_wb_wr = wbw;
        i_wb_rd = wbrd;
        i_flush = fl;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic test_reset();
        idle();
        tests++;
        if (o_busy_mask !== 32'd0 || o_inflight !== 2'd0 || o_issue !== 1'b0 ||
            o_stall !== 1'b0 || o_underflow !== 1'b0) begin
            $display("FAIL reset_state: busy=%h infl=%0d iss=%b stl=%b uf=%b, want all 0",
                     o_busy_mask, o_inflight, o_issue, o_stall, o_underflow);
            fails++;
        end
        // Build cnt[5]=2, in-flight=2
        drive(1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0);
        step();
        step();
        drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
        tests++;
        if (o_inflight !== 2'd2 || o_busy_mask[5] !== 1'b1 || o_stall !== 1'b1) begin
            $display("FAIL reset_preload: infl=%0d busy5=%b stl=%b, want 2 1 1",
                     o_inflight, o_busy_mask[5], o_stall);
            fails++;
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if (o_busy_mask !== 32'd0 || o_inflight !== 2'd0 || o_stall !== 1'b0) begin
            $display("FAIL reset_async: busy=%h infl=%0d stl=%b, want 0 0 0",
                     o_busy_mask, o_inflight, o_stall);
            fails++;
        end
        rst_n = 1'b1;
        #1;
        tests++;
        if (o_issue !== 1'b1) begin
            $display("FAIL reset_release_issue: issue=%b, want 1", o_issue);
            fails++;
        end
        step();
        idle();
    endtask

    task automatic test_raw();
        drive(1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0);
        tests++;
        if (o_issue !== 1'b1) begin
            $display("FAIL raw_addi_issue: issue=%b, want 1", o_issue);
            fails++;
        end
        step();
        drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
        tests++;
        if (o_issue !== 1'b0 || o_stall !== 1'b1) begin
            $display("FAIL raw_stall: issue=%b stall=%b, want 0 1", o_issue, o_stall);
            fails++;
        end
        step();
        tests++;
        if (o_issue !== 1'b0 || o_stall !== 1'b1) begin
            $display("FAIL raw_stall_hold: issue=%b stall=%b, want 0 1", o_issue, o_stall);
            fails++;
        end
        drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0);
        tests++;
        if (o_issue !== 1'b1 || o_stall !== 1'b0) begin
            $display("FAIL raw_bypass: issue=%b stall=%b, want 1 0", o_issue, o_stall);
            fails++;
        end
        step();
        idle();
        tests++;
        if (o_busy_mask[5] !== 1'b0 || o_inflight !== 2'd0) begin
            $display("FAIL raw_retired: busy5=%b infl=%0d, want 0 0",
                     o_busy_mask[5], o_inflight);
            fails++;
        end
    endtask

    task automatic test_same_cycle();
        drive(1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 5'd0, 1'b0);
        step();
        drive(1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0);
        tests++;
        if (o_issue !== 1'b1) begin
            $display("FAIL same_issue: issue=%b, want 1", o_issue);
            fails++;
        end
        step();
        idle();
        tests++;
        if (o_busy_mask !== 32'h0000_0080 || o_inflight !== 2'd1) begin
            $display("FAIL same_hold: busy=%h infl=%0d, want 00000080 1",
                     o_busy_mask, o_inflight);
            fails++;
        end
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd7, 1'b0);
        step();
        idle();
        tests++;
        if (o_busy_mask !== 32'd0 || o_inflight !== 2'd0) begin
            $display("FAIL same_drain: busy=%h infl=%0d, want 0 0", o_busy_mask, o_inflight);
            fails++;
        end
    endtask

    task automatic test_inflight_limit();
        for (int r = 1; r <= 3; r++) begin
            drive(1'b1, 5'd0, 1'b0, 5'(r), 1'b1, 1'b0, 5'd0, 1'b0);
            step();
        end
        drive(1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 5'd0, 1'b0);
        tests++;
        if (o_inflight !== 2'd3 || o_issue !== 1'b0 || o_stall !== 1'b1) begin
            $display("FAIL limit_block: infl=%0d issue=%b stall=%b, want 3 0 1",
                     o_inflight, o_issue, o_stall);
            fails++;
        end
        drive(1'b1, 5'd10, 1'b1, 5'd4, 1'b0, 1'b0, 5'd0, 1'b0);
        tests++;
        if (o_issue !== 1'b1) begin
            $display("FAIL limit_nonwriter: issue=%b, want 1", o_issue);
            fails++;
        end
        i_ex_stall = 1'b1;
        #1;
        tests++;
        if (o_issue !== 1'b0 || o_stall !== 1'b1) begin
            $display("FAIL ex_stall: issue=%b stall=%b, want 0 1", o_issue, o_stall);
            fails++;
        end
        for (int r = 1; r <= 3; r++) begin
            drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'(r), 1'b0);
            step();
        end
        idle();
        tests++;
        if (o_inflight !== 2'd0 || o_busy_mask !== 32'd0) begin
            $display("FAIL limit_drain: infl=%0d busy=%h, want 0 0", o_inflight, o_busy_mask);
            fails++;
        end
    endtask

    task automatic test_waw();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 5'd0, 1'b0);
            step();
        end
        drive(1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 5'd0, 1'b0);
        tests++;
        if (o_issue !== 1'b0 || o_stall !== 1'b1) begin
            $display("FAIL waw_full: issue=%b stall=%b, want 0 1", o_issue, o_stall);
            fails++;
        end
        drive(1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1, 5'd6, 1'b0);
        tests++;
        if (o_issue !== 1'b1) begin
            $display("FAIL waw_wb_relief: issue=%b, want 1", o_issue);
            fails++;
        end
        step();
        idle();
        tests++;
        if (o_inflight !== 2'd3 || o_busy_mask !== 32'h0000_0040) begin
            $display("FAIL waw_hold: infl=%0d busy=%h, want 3 00000040",
                     o_inflight, o_busy_mask);
            fails++;
        end
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1);
        step();
        idle();
    endtask

    task automatic test_flush();
        drive(1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 5'd0, 1'b0);
        step();
        step();
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd3, 1'b1);
        tests++;
        if (o_inflight !== 2'd2 || o_issue !== 1'b0 || o_stall !== 1'b0) begin
            $display("FAIL flush_cycle: infl=%0d issue=%b stall=%b, want 2 0 0",
                     o_inflight, o_issue, o_stall);
            fails++;
        end
        step();
        idle();
        tests++;
        if (o_busy_mask !== 32'd0 || o_inflight !== 2'd0 || o_underflow !== 1'b0) begin
            $display("FAIL flush_clear: busy=%h infl=%0d uf=%b, want 0 0 0",
                     o_busy_mask, o_inflight, o_underflow);
            fails++;
        end
    endtask

    task automatic test_underflow();
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0);
        tests++;
        if (o_issue !== 1'b1) begin
            $display("FAIL x0_issue: issue=%b, want 1", o_issue);
            fails++;
        end
        step();
        idle();
        tests++;
        if (o_underflow !== 1'b0 || o_busy_mask !== 32'd0 || o_inflight !== 2'd0) begin
            $display("FAIL x0_ignored: uf=%b busy=%h infl=%0d, want 0 0 0",
                     o_underflow, o_busy_mask, o_inflight);
            fails++;
        end
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd9, 1'b0);
        step();
        idle();
        tests++;
        if (o_underflow !== 1'b1 || o_busy_mask !== 32'd0 || o_inflight !== 2'd0) begin
            $display("FAIL underflow_set: uf=%b busy=%h infl=%0d, want 1 0 0",
                     o_underflow, o_busy_mask, o_inflight);
            fails++;
        end
        drive(1'b1, 5'd0, 1'b0, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0);
        step();
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd2, 1'b0);
        step();
        idle();
        step();
        tests++;
        if (o_underflow !== 1'b1 || o_inflight !== 2'd0) begin
            $display("FAIL underflow_sticky: uf=%b infl=%0d, want 1 0", o_underflow, o_inflight);
            fails++;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        #12;
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_raw();
        test_same_cycle();
        test_inflight_limit();
        test_waw();
        test_flush();
        test_underflow();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global time bound so the run always terminates
    initial begin
        #100000;
        $display("FAIL timeout: sim time %0t, want completion earlier", $time);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Issue-control block between the Decode stage and Execute.
- Tracks, per architectural register, how many issued but not yet written-back instructions target it.
- Blocks issue of a decoded instruction on a RAW hazard, on a WAW counter saturation, or when the in-flight writer limit is reached.
- Drives the Decode stall and the "issue fires" qualifier that Decode uses to capture its pipeline registers.

Parameters:
- N_REGS, 32, number of architectural registers; x0 is never tracked.
- CNT_W, 2, width of each per-register pending counter; saturation value is 2**CNT_W-1.
- MAX_INFLIGHT, 3, maximum writer instructions between issue and writeback.
- WB_BYPASS, 1, if 1, a source whose only pending write is retiring this cycle does not stall.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- i_issue_valid  input  1  Decode holds a valid decoded instruction.
- i_rs1  input  5  source register 1 index.
- i_rs2  input  5  source register 2 index.
- i_rs1_used  input  1  instruction reads rs1.
- i_rs2_used  input  1  instruction reads rs2.
- i_rd  input  5  destination register index.
- i_rd_wr  input  1  instruction writes rd.
- i_ex_stall  input  1  Execute cannot accept an instruction this cycle.
- i_wb_wr  input  1  writeback writes the register file this cycle.
- i_wb_rd  input  5  writeback destination index.
- i_flush  input  1  pipeline flush; EX/MEM contents are discarded.
- o_issue  output  1  instruction issues this cycle (Decode captures it).
- o_stall  output  1  Decode/Fetch must hold the current instruction.
- o_busy_mask  output  N_REGS  bit r = pending counter of r is nonzero; bit 0 is always 0.
- o_inflight  output  2  current in-flight writer count.
- o_underflow  output  1  sticky error: writeback seen for a register with zero pending.

Behaviour:
- Reset (async, rst_n=0): all counters 0, in-flight 0, o_underflow 0. Consequently o_busy_mask=0, o_issue=0, o_stall=0.
- Definitions:
  - wb_hit = i_wb_wr & i_wb_rd!=0 & cnt[i_wb_rd]!=0.
  - src_haz(rs,used) = used & rs!=0 & cnt[rs]!=0, except when WB_BYPASS=1 & wb_hit & i_wb_rd==rs & cnt[rs]==1.
  - waw_full = i_rd_wr & i_rd!=0 & cnt[i_rd]==max & ~(wb_hit & i_wb_rd==i_rd).
  - lim_full = (in-flight==MAX_INFLIGHT) & ~wb_hit, applied only when i_rd_wr & i_rd!=0.
- o_issue = i_issue_valid & ~i_ex_stall & ~i_flush & ~src_haz(rs1) & ~src_haz(rs2) & ~waw_full & ~lim_full. This is combinational from registered state plus inputs (zero latency).
- o_stall = i_issue_valid & ~o_issue & ~i_flush.
- Counter update, per clock edge:
  - inc = o_issue & i_rd_wr & i_rd!=0.
  - cnt[i_rd] += inc, cnt[i_wb_rd] -= wb_hit.
  - If both target the same register, the counter is unchanged.
  - in-flight += inc, -= wb_hit; both together leave it unchanged.
- Underflow: i_wb_wr & i_wb_rd!=0 & cnt[i_wb_rd]==0 changes no counter and sets o_underflow=1. o_underflow clears only on reset.
- x0 writes never increment or decrement anything. i_wb_rd=0 with i_wb_wr=1 is legal and silently ignored.
- Flush:
  - i_flush=1 clears all counters and in-flight to 0 on the next edge.
  - Any writeback in the same cycle is ignored.
  - o_issue is forced to 0 that cycle.
  - o_underflow is unaffected.
- o_busy_mask and o_inflight are pure functions of the registered state, so they are valid one cycle after the causing event.
- Counters never wrap. Saturation is prevented by waw_full. Overflow past MAX_INFLIGHT is prevented by lim_full.

Test Plan:
- Reset with rst_n low mid-operation (cnt[5]=2, in-flight=2) -> immediately o_busy_mask=0, o_inflight=0, o_stall=0; after release, issue of rs1=5 fires.
- Issue ADDI x5 (rd_wr=1), next cycle issue ADD rs1=5 -> o_stall=1, o_issue=0. The stall persists until i_wb_wr with i_wb_rd=5. With WB_BYPASS=1, o_issue=1 in that writeback cycle and o_busy_mask[5]=0 the following cycle.
- Issue and writeback of rd=7 in the same cycle with cnt[7]=1 -> cnt[7] stays 1, in-flight unchanged, o_busy_mask[7]=1.
- Three consecutive writer issues to x1, x2, x3 with no writeback -> o_inflight=3. A fourth writer (rd=4) stalls; a non-writer (rd_wr=0, sources free) still issues.
- i_flush with cnt[3]=2, in-flight=2 and a simultaneous wb to x3 -> next cycle o_busy_mask=0, o_inflight=0, o_underflow=0.
- i_wb_wr=1, i_wb_rd=9 with cnt[9]=0 -> o_underflow=1 and stays 1 after further traffic. i_wb_rd=0 -> no flag; rd=0 writers never set busy bit 0.
